// File: rtl/pe_is_pkg.sv
// Shared types and helpers for the multi-context input-stationary PE.
package pe_is_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StCompute = 2'd2
    } pe_state_e;

    // Widest accumulator the saturation helpers can describe.
    localparam int unsigned MaxMacW = 128;

    function automatic int unsigned ctx_width(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

    // Largest representable value of a w-bit accumulator (low w bits are meaningful).
    function automatic logic [MaxMacW-1:0] sat_hi(input int unsigned w, input bit sgn);
        return (MaxMacW'(1) << (sgn ? w - 1 : w)) - MaxMacW'(1);
    endfunction

    // Smallest representable value of a w-bit accumulator (low w bits are meaningful).
    function automatic logic [MaxMacW-1:0] sat_lo(input int unsigned w, input bit sgn);
        return sgn ? ~sat_hi(w, 1'b1) : '0;
    endfunction

endpackage

// File: rtl/pe_is_act_bank.sv
// DEPTH-entry activation register file filled sequentially through a wrapping load pointer.
module pe_is_act_bank
    import pe_is_pkg::*;
#(
    parameter int unsigned WIDTH_A = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CTX_W   = ctx_width(DEPTH)
) (
    input  logic               clk,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  logic [WIDTH_A-1:0] wr_data_i,
    input  logic [CTX_W-1:0]   rd_ctx_i,
    output logic [WIDTH_A-1:0] rd_data_o,
    output logic               wr_last_o
);

    logic [WIDTH_A-1:0] mem_q [DEPTH];
    logic [CTX_W-1:0]   ptr_q;

    assign wr_last_o = wr_en_i && (32'(ptr_q) == DEPTH - 1);

    // Sequential fill; the pointer wraps to entry 0 after the last write so a reload starts clean.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[ptr_q] <= wr_data_i;
            ptr_q        <= wr_last_o ? '0 : ptr_q + CTX_W'(1);
        end
    end

    // Combinational read; out-of-range contexts read as zero.
    always_comb begin
        rd_data_o = '0;
        if (32'(rd_ctx_i) < DEPTH) begin
            rd_data_o = mem_q[rd_ctx_i];
        end
    end

endmodule

// File: rtl/processing_element_is_mc.sv
// Multi-context input-stationary systolic PE: psum_out = psum_in + act[ctx] * wei.
// Optional build macro PE_IS_MC_SATURATE_EN clamps the accumulation instead of wrapping.
module processing_element_is_mc
    import pe_is_pkg::*;
#(
    parameter int unsigned WIDTH_A   = 16,
    parameter int unsigned WIDTH_B   = 16,
    parameter int unsigned WIDTH_MAC = 48,
    parameter int unsigned WIDTH_T   = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned STAGE     = 1,
    parameter bit          SIGNED    = 1'b1,
    parameter bit          ZERO_GATE = 1'b1,
    localparam int unsigned CTX_W    = ctx_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_clear,
    input  logic                 pipeline_en,
    input  logic                 load_start,
    input  logic [WIDTH_A-1:0]   act_in,
    input  logic                 act_in_valid,
    output logic [WIDTH_A-1:0]   act_out,
    output logic                 act_out_valid,
    input  logic [WIDTH_B-1:0]   wei_in,
    input  logic                 wei_in_valid,
    input  logic [CTX_W-1:0]     wei_ctx_in,
    output logic [WIDTH_B-1:0]   wei_out,
    output logic [CTX_W-1:0]     wei_ctx_out,
    output logic                 wei_out_valid,
    input  logic [WIDTH_MAC-1:0] psum_in,
    output logic [WIDTH_MAC-1:0] psum_out,
    output logic                 psum_out_valid,
    input  logic [WIDTH_T-1:0]   Thres,
    output logic                 load_done,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned PW   = WIDTH_A + WIDTH_B;
    localparam int unsigned NStg = (STAGE > 0) ? STAGE : 1;

    pe_state_e          state_q;
    logic               clr, wr_en, wr_last, ctx_ok, accept, gate;
    logic [WIDTH_A-1:0] act_sel, act_mag;
    logic [WIDTH_B-1:0] wei_mag;
    logic [PW-1:0]      a_ext, b_ext, prod_c;

    assign clr     = rst | reg_clear;
    assign wr_en   = (state_q == StLoad) && act_in_valid;
    assign ctx_ok  = 32'(wei_ctx_in) < DEPTH;
    assign accept  = (state_q == StCompute) && wei_in_valid && pipeline_en && ctx_ok;
    assign busy    = (state_q != StIdle);

    pe_is_act_bank #(
        .WIDTH_A (WIDTH_A),
        .DEPTH   (DEPTH),
        .CTX_W   (CTX_W)
    ) u_bank (
        .clk       (clk),
        .clr_i     (clr),
        .wr_en_i   (wr_en),
        .wr_data_i (act_in),
        .rd_ctx_i  (wei_ctx_in),
        .rd_data_o (act_sel),
        .wr_last_o (wr_last)
    );

    // Control FSM plus the registered activation forward, load_done pulse and sticky error.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= StIdle;
            load_done     <= 1'b0;
            err           <= 1'b0;
            act_out       <= '0;
            act_out_valid <= 1'b0;
        end else begin
            load_done     <= wr_last;
            act_out_valid <= act_in_valid && (state_q != StLoad);
            if (act_in_valid && (state_q != StLoad)) begin
                act_out <= act_in;
            end
            if (wei_in_valid && ((state_q != StCompute) || !ctx_ok)) begin
                err <= 1'b1;
            end
            unique case (state_q)
                StIdle:    if (load_start) state_q <= StLoad;
                StLoad:    if (wr_last) state_q <= StCompute;
                StCompute: if (load_start) state_q <= StLoad;
                default:   state_q <= StIdle;
            endcase
        end
    end

    // Weight forwarding follows the pipeline enable regardless of state.
    always_ff @(posedge clk) begin
        if (clr) begin
            wei_out       <= '0;
            wei_ctx_out   <= '0;
            wei_out_valid <= 1'b0;
        end else if (pipeline_en) begin
            wei_out       <= wei_in;
            wei_ctx_out   <= wei_ctx_in;
            wei_out_valid <= wei_in_valid;
        end
    end

    // Operand extension, magnitude threshold test and full-width product.
    always_comb begin
        act_mag = (SIGNED && act_sel[WIDTH_A-1]) ? -act_sel : act_sel;
        wei_mag = (SIGNED && wei_in[WIDTH_B-1]) ? -wei_in : wei_in;
        gate    = ZERO_GATE && (((act_mag >> Thres) == '0) || ((wei_mag >> Thres) == '0));
        a_ext   = SIGNED ? {{WIDTH_B{act_sel[WIDTH_A-1]}}, act_sel} : {{WIDTH_B{1'b0}}, act_sel};
        b_ext   = SIGNED ? {{WIDTH_A{wei_in[WIDTH_B-1]}}, wei_in} : {{WIDTH_A{1'b0}}, wei_in};
        prod_c  = a_ext * b_ext;
    end

    logic [NStg-1:0]      vld_q, zero_q;
    logic [PW-1:0]        prod_q [NStg];
    logic [WIDTH_MAC-1:0] psi_q  [NStg];

    // Valid-tracked multiply pipeline; gated products leave the product registers untouched.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q  <= '0;
            zero_q <= '0;
            for (int i = 0; i < int'(NStg); i++) begin
                prod_q[i] <= '0;
                psi_q[i]  <= '0;
            end
        end else if (pipeline_en) begin
            vld_q[0]  <= accept;
            zero_q[0] <= gate;
            if (accept) psi_q[0] <= psum_in;
            if (accept && !gate) prod_q[0] <= prod_c;
            for (int i = 1; i < int'(NStg); i++) begin
                vld_q[i]  <= vld_q[i-1];
                zero_q[i] <= zero_q[i-1];
                if (vld_q[i-1]) psi_q[i] <= psi_q[i-1];
                if (vld_q[i-1] && !zero_q[i-1]) prod_q[i] <= prod_q[i-1];
            end
        end
    end

    logic                 tail_vld, tail_zero;
    logic [PW-1:0]        tail_prod;
    logic [WIDTH_MAC-1:0] tail_psum, prod_ext, sum;

    if (STAGE == 0) begin : g_comb_mult
        assign tail_vld  = accept;
        assign tail_zero = gate;
        assign tail_prod = prod_c;
        assign tail_psum = psum_in;
    end else begin : g_reg_mult
        assign tail_vld  = vld_q[NStg-1];
        assign tail_zero = zero_q[NStg-1];
        assign tail_prod = prod_q[NStg-1];
        assign tail_psum = psi_q[NStg-1];
    end

`ifdef PE_IS_MC_SATURATE_EN
    localparam logic [WIDTH_MAC-1:0] SatHi = WIDTH_MAC'(sat_hi(WIDTH_MAC, SIGNED));
    localparam logic [WIDTH_MAC-1:0] SatLo = WIDTH_MAC'(sat_lo(WIDTH_MAC, SIGNED));
    logic [WIDTH_MAC:0] sum_w;
`endif

    // Accumulate; clamp on overflow when saturation is built in, otherwise wrap.
    always_comb begin
        prod_ext = tail_zero ? '0 : (SIGNED ? WIDTH_MAC'($signed(tail_prod)) : WIDTH_MAC'(tail_prod));
`ifdef PE_IS_MC_SATURATE_EN
        sum_w = {1'b0, tail_psum} + {1'b0, prod_ext};
        sum   = sum_w[WIDTH_MAC-1:0];
        if (SIGNED) begin
            if ((tail_psum[WIDTH_MAC-1] == prod_ext[WIDTH_MAC-1]) &&
                (sum[WIDTH_MAC-1] != tail_psum[WIDTH_MAC-1])) begin
                sum = tail_psum[WIDTH_MAC-1] ? SatLo : SatHi;
            end
        end else if (sum_w[WIDTH_MAC]) begin
            sum = SatHi;
        end
`else
        sum = tail_psum + prod_ext;
`endif
    end

    // Registered result stage; holds while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (clr) begin
            psum_out       <= '0;
            psum_out_valid <= 1'b0;
        end else if (pipeline_en) begin
            psum_out_valid <= tail_vld;
            if (tail_vld) psum_out <= sum;
        end
    end

endmodule

// File: tb/tb_processing_element_is_mc.sv
// Bench for processing_element_is_mc (default parameters, DEPTH=4, STAGE=1, signed, gating on).
module tb_processing_element_is_mc;

    localparam int STAGE = 1;

    logic        clk = 1'b0;
    logic        rst, reg_clear, pipeline_en, load_start;
    logic [15:0] act_in, act_out;
    logic        act_in_valid, act_out_valid;
    logic [15:0] wei_in, wei_out;
    logic        wei_in_valid, wei_out_valid;
    logic [1:0]  wei_ctx_in, wei_ctx_out;
    logic [47:0] psum_in, psum_out;
    logic        psum_out_valid;
    logic [1:0]  Thres;
    logic        load_done, busy, err;

    always #5 clk = ~clk;

    processing_element_is_mc #(.STAGE(STAGE)) dut (
        .clk            (clk),
        .rst            (rst),
        .reg_clear      (reg_clear),
        .pipeline_en    (pipeline_en),
        .load_start     (load_start),
        .act_in         (act_in),
        .act_in_valid   (act_in_valid),
        .act_out        (act_out),
        .act_out_valid  (act_out_valid),
        .wei_in         (wei_in),
        .wei_in_valid   (wei_in_valid),
        .wei_ctx_in     (wei_ctx_in),
        .wei_out        (wei_out),
        .wei_ctx_out    (wei_ctx_out),
        .wei_out_valid  (wei_out_valid),
        .psum_in        (psum_in),
        .psum_out       (psum_out),
        .psum_out_valid (psum_out_valid),
        .Thres          (Thres),
        .load_done      (load_done),
        .busy           (busy),
        .err            (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: state 0=idle 1=load 2=compute, results queued with enabled-cycle countdowns.
    typedef struct {
        logic [47:0] val;
        int          rem;
    } pend_t;

    int          m_state, m_ptr;
    logic [15:0] m_bank [4];
    bit          m_err, m_ld, m_aov, m_wov, m_pv;
    logic [15:0] m_ao, m_wo;
    logic [1:0]  m_wc;
    logic [47:0] m_pval;
    pend_t       pq[$];

    function automatic logic [47:0] ref_result(input logic [15:0] a, input logic [15:0] w,
                                               input logic [47:0] p, input logic [1:0] t);
        longint av, wv, pv, lim, prod, sum;
        av   = longint'($signed(a));
        wv   = longint'($signed(w));
        pv   = longint'($signed(p));
        lim  = longint'(1) << t;
        prod = 0;
        if (!(((av < 0) ? -av : av) < lim || ((wv < 0) ? -wv : wv) < lim)) prod = av * wv;
        sum = pv + prod;
`ifdef PE_IS_MC_SATURATE_EN
        if (sum > (longint'(1) << 47) - 1) sum = (longint'(1) << 47) - 1;
        if (sum < -(longint'(1) << 47)) sum = -(longint'(1) << 47);
`endif
        return 48'(sum);
    endfunction

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_err = 0; m_ld = 0;
        m_aov = 0; m_ao = '0; m_wov = 0; m_wo = '0; m_wc = '0;
        m_pv = 0; m_pval = '0;
        for (int i = 0; i < 4; i++) m_bank[i] = '0;
        pq.delete();
    endtask

    // Advance the model with the current inputs, clock the DUT, then compare everything.
    task automatic tick();
        bit          acc;
        logic [47:0] r;
        r = '0;
        if (rst || reg_clear) begin
            model_reset();
        end else begin
            acc = (m_state == 2) && wei_in_valid && pipeline_en;
            if (acc) r = ref_result(m_bank[wei_ctx_in], wei_in, psum_in, Thres);
            if (wei_in_valid && m_state != 2) m_err = 1;
            m_aov = act_in_valid && (m_state != 1);
            if (m_aov) m_ao = act_in;
            m_ld = 0;
            case (m_state)
                0: if (load_start) m_state = 1;
                1: if (act_in_valid) begin
                    m_bank[m_ptr] = act_in;
                    if (m_ptr == 3) begin
                        m_ptr = 0; m_ld = 1; m_state = 2;
                    end else begin
                        m_ptr++;
                    end
                end
                default: if (load_start) m_state = 1;
            endcase
            if (pipeline_en) begin
                m_wo = wei_in; m_wc = wei_ctx_in; m_wov = wei_in_valid;
                if (acc) pq.push_back('{val: r, rem: STAGE + 1});
                for (int i = 0; i < pq.size(); i++) pq[i].rem = pq[i].rem - 1;
                m_pv = 0;
                if (pq.size() > 0 && pq[0].rem == 0) begin
                    m_pv = 1; m_pval = pq[0].val;
                    void'(pq.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        chk("busy", busy, m_state != 0);
        chk("load_done", load_done, m_ld);
        chk("err", err, m_err);
        chk("act_out_valid", act_out_valid, m_aov);
        chk("act_out", act_out, m_ao);
        chk("wei_out_valid", wei_out_valid, m_wov);
        chk("wei_out", wei_out, m_wo);
        chk("wei_ctx_out", wei_ctx_out, m_wc);
        chk("psum_out_valid", psum_out_valid, m_pv);
        chk("psum_out", psum_out, m_pval);
    endtask

    task automatic quiet();
        rst = 0; reg_clear = 0; pipeline_en = 1; load_start = 0;
        act_in = '0; act_in_valid = 0; wei_in = '0; wei_in_valid = 0;
        wei_ctx_in = '0; psum_in = '0; Thres = '0;
    endtask

    task automatic load_bank(input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] a2, input logic [15:0] a3);
        logic [15:0] v [4];
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        load_start = 1; tick(); load_start = 0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 4; i++) begin
            act_in = v[i]; act_in_valid = 1; tick();
            chk("load_done_pulse", load_done, i == 3);
            chk("act_consumed", act_out_valid, 0);
        end
        act_in_valid = 0;
    endtask

    typedef struct {
        logic [1:0]  ctx;
        logic [15:0] wei;
        logic [47:0] psum;
        logic [1:0]  thr;
        logic [47:0] exp;
    } vec_t;

    vec_t tbl [7];
    int   lat;

    initial begin
        // Bank for the table: {3, -4, 1, 32767}.
        tbl[0] = '{ctx: 2'd0, wei: 16'd50,    psum: 48'd7, thr: 2'd2, exp: 48'd7};
        tbl[1] = '{ctx: 2'd1, wei: 16'd3,     psum: 48'd0, thr: 2'd0, exp: 48'hFFFF_FFFF_FFF4};
`ifdef PE_IS_MC_SATURATE_EN
        tbl[2] = '{ctx: 2'd2, wei: 16'd1, psum: 48'h7FFF_FFFF_FFFF, thr: 2'd0,
                   exp: 48'h7FFF_FFFF_FFFF};
        tbl[6] = '{ctx: 2'd1, wei: 16'd1, psum: 48'h8000_0000_0000, thr: 2'd0,
                   exp: 48'h8000_0000_0000};
`else
        tbl[2] = '{ctx: 2'd2, wei: 16'd1, psum: 48'h7FFF_FFFF_FFFF, thr: 2'd0,
                   exp: 48'h8000_0000_0000};
        tbl[6] = '{ctx: 2'd1, wei: 16'd1, psum: 48'h8000_0000_0000, thr: 2'd0,
                   exp: 48'h7FFF_FFFF_FFFC};
`endif
        tbl[3] = '{ctx: 2'd3, wei: 16'hFFFE,  psum: 48'd5, thr: 2'd0, exp: 48'hFFFF_FFFF_0007};
        tbl[4] = '{ctx: 2'd1, wei: 16'd3,     psum: 48'd0, thr: 2'd2, exp: 48'd0};
        tbl[5] = '{ctx: 2'd3, wei: 16'h7FFF,  psum: 48'd0, thr: 2'd3, exp: 48'h3FFF_0001};

        quiet();
        rst = 1; tick(); tick(); rst = 0;
        chk("rst_psum_out", psum_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);

        // Load 3,5,7,9 then a fifth activation is forwarded.
        load_bank(16'd3, 16'd5, 16'd7, 16'd9);
        act_in = 16'd11; act_in_valid = 1; tick(); act_in_valid = 0;
        chk("fwd_act_out", act_out, 11);
        chk("fwd_act_valid", act_out_valid, 1);

        // wei=2, ctx=2 (act 7), psum_in=100 -> 114 two cycles later.
        wei_in = 16'd2; wei_ctx_in = 2'd2; psum_in = 48'd100; wei_in_valid = 1; tick();
        wei_in_valid = 0;
        chk("wei_out_1cyc", wei_out, 2);
        chk("psum_not_yet", psum_out_valid, 0);
        tick();
        chk("psum_valid_2cyc", psum_out_valid, 1);
        chk("psum_114", psum_out, 114);

        // Reload (COMPUTE -> LOAD) and run the table.
        load_bank(16'd3, 16'hFFFC, 16'd1, 16'h7FFF);
        for (int i = 0; i < 7; i++) begin
            wei_ctx_in = tbl[i].ctx; wei_in = tbl[i].wei; psum_in = tbl[i].psum;
            Thres = tbl[i].thr; wei_in_valid = 1; tick();
            wei_in_valid = 0; tick();
            chk($sformatf("tbl%0d_valid", i), psum_out_valid, 1);
            chk($sformatf("tbl%0d_psum", i), psum_out, tbl[i].exp);
        end
        Thres = '0;

        // Three stalled cycles stretch the latency from 2 to 5.
        wei_ctx_in = 2'd1; wei_in = 16'd3; psum_in = 48'd0; wei_in_valid = 1; tick();
        wei_in_valid = 0; lat = 1;
        while (!psum_out_valid && lat < 20) begin
            pipeline_en = (lat <= 3) ? 1'b0 : 1'b1;
            tick(); lat++;
        end
        pipeline_en = 1;
        chk("stall_latency", lat, 5);
        chk("stall_psum", psum_out, 48'hFFFF_FFFF_FFF4);

        // Weight during LOAD is an error and never produces a result.
        chk("err_clean", err, 0);
        load_start = 1; tick(); load_start = 0;
        wei_in = 16'd5; wei_ctx_in = 2'd0; wei_in_valid = 1; tick(); wei_in_valid = 0;
        chk("err_load", err, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_no_psum", psum_out_valid, 0);
        end
        chk("err_sticky", err, 1);

        // Soft clear in the middle of a load.
        act_in = 16'd4; act_in_valid = 1; tick(); tick(); act_in_valid = 0;
        reg_clear = 1; tick(); reg_clear = 0;
        chk("clr_busy", busy, 0);
        chk("clr_err", err, 0);
        chk("clr_wei_out", wei_out, 0);
        chk("clr_psum_out", psum_out, 0);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            reg_clear    = ($urandom_range(0, 299) == 0);
            load_start   = ($urandom_range(0, 29) == 0);
            pipeline_en  = ($urandom_range(0, 4) != 0);
            act_in_valid = $urandom_range(0, 1);
            act_in       = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) - 16'd10
                                                       : 16'($urandom);
            wei_in_valid = ($urandom_range(0, 2) == 0);
            wei_in       = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) - 16'd10
                                                       : 16'($urandom);
            wei_ctx_in   = 2'($urandom_range(0, 3));
            psum_in      = {16'($urandom), 32'($urandom)};
            Thres        = 2'($urandom_range(0, 3));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
